// File: rtl/mem_dump_ctrl.sv
// Walks an address range of a memory's combinational read port and streams (addr,data) records.
module mem_dump_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    output logic [AW-1:0] mem_addr,
    output logic          mem_ren,
    input  logic [DW-1:0] mem_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic [AW:0]   sent_cnt
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] SEND  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]    state;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   remaining;

    // The read address is the walk pointer itself, so the memory sees a registered address.
    assign mem_addr = cur_addr;
    assign mem_ren  = (state == FETCH);
    assign busy     = (state == FETCH) || (state == SEND);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            sent_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sent_cnt <= '0;
                        if (length != '0) begin
                            cur_addr  <= base_addr;
                            remaining <= length;
                            state     <= FETCH;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        out_data  <= mem_rdata;
                        out_addr  <= cur_addr;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // Abort wins over a handshake in the same cycle; that record is not counted.
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        sent_cnt  <= sent_cnt + (AW+1)'(1);
                        if (remaining == (AW+1)'(1)) begin
                            state <= DONE;
                        end else begin
                            cur_addr  <= cur_addr + AW'(1);
                            remaining <= remaining - (AW+1)'(1);
                            state     <= FETCH;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Directed bench for mem_dump_ctrl: table-driven dumps plus reset/abort corner sequences.
module tb_mem_dump_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [AW-1:0] mem_addr;
    logic          mem_ren;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic [AW:0]   sent_cnt;

    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_dump_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .length    (length),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .sent_cnt  (sent_cnt)
    );

    typedef struct {
        logic [7:0] base;
        logic [8:0] len;
        int         stall_idx;   // record index held off by out_ready=0 (-1: none)
        int         stall_n;
        int         abort_idx;   // record index whose SEND cycle gets abort (-1: none)
        bit         busy_start;  // pulse start with other base/len while busy
        int         exp_sent;
        bit         exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int         cyc;
        int         k;
        int         stalled;
        bit         fin;
        bit         saw_done;
        bit         first;
        logic [7:0] ea;
        cyc = 0; k = 0; stalled = 0; fin = 1'b0; saw_done = 1'b0; first = 1'b1;
        @(negedge clk);
        start = 1'b1; base_addr = v.base; length = v.len; out_ready = 1'b1; abort = 1'b0;
        while (!fin && cyc < 700) begin
            @(negedge clk);
            cyc++;
            start = v.busy_start && (cyc == 1);
            if (v.busy_start && cyc == 1) begin
                base_addr = 8'h60;
                length    = 9'd5;
            end
            abort = 1'b0;
            if (out_valid) begin
                ea = v.base + 8'(k);
                if (first) begin
                    check($sformatf("v%0d latency", id), 32'(cyc), 32'd2);
                    first = 1'b0;
                end
                check($sformatf("v%0d rec%0d addr", id, k), 32'(out_addr), 32'(ea));
                check($sformatf("v%0d rec%0d data", id, k), 32'(out_data), 32'(mem[ea]));
                if (k == v.abort_idx) begin
                    abort = 1'b1;
                    out_ready = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check($sformatf("v%0d abort valid", id), 32'(out_valid), 32'd0);
                    check($sformatf("v%0d abort busy", id), 32'(busy), 32'd0);
                    check($sformatf("v%0d abort sent_cnt", id), 32'(sent_cnt), 32'(v.exp_sent));
                    for (int i = 0; i < 4; i++) begin
                        if (done) saw_done = 1'b1;
                        @(negedge clk);
                    end
                    fin = 1'b1;
                end else if (k == v.stall_idx && stalled < v.stall_n) begin
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    k++;
                end
            end else if (done) begin
                saw_done = 1'b1;
                check($sformatf("v%0d record count", id), 32'(k), 32'(v.exp_sent));
                check($sformatf("v%0d sent_cnt", id), 32'(sent_cnt), 32'(v.exp_sent));
                if (v.len == 9'd0)
                    check($sformatf("v%0d len0 done latency", id), 32'(cyc), 32'd1);
                @(negedge clk);
                check($sformatf("v%0d done width", id), 32'(done), 32'd0);
                fin = 1'b1;
            end
        end
        if (!fin)
            check($sformatf("v%0d timeout", id), 32'd1, 32'd0);
        check($sformatf("v%0d done seen", id), 32'(saw_done), 32'(v.exp_done));
        if (v.stall_idx >= 0)
            check($sformatf("v%0d stall cycles", id), 32'(stalled), 32'(v.stall_n));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " done"},      32'(done),      32'd0);
        check({tag, " mem_ren"},   32'(mem_ren),   32'd0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, " out_addr"},  32'(out_addr),  32'd0);
        check({tag, " out_data"},  32'(out_data),  32'd0);
        check({tag, " sent_cnt"},  32'(sent_cnt),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'hA0; mem[8'h11] = 8'hA1; mem[8'h12] = 8'hA2; mem[8'h13] = 8'hA3;

        vecs[0] = '{8'h10, 9'd4,   -1, 0, -1, 1'b0, 4,   1'b1};
        vecs[1] = '{8'h10, 9'd4,    1, 5, -1, 1'b0, 4,   1'b1};
        vecs[2] = '{8'hFE, 9'd4,   -1, 0, -1, 1'b0, 4,   1'b1};
        vecs[3] = '{8'h33, 9'd0,   -1, 0, -1, 1'b0, 0,   1'b1};
        vecs[4] = '{8'h20, 9'd8,   -1, 0,  2, 1'b0, 2,   1'b0};
        vecs[5] = '{8'h28, 9'd3,   -1, 0, -1, 1'b0, 3,   1'b1};
        vecs[6] = '{8'h50, 9'd3,   -1, 0, -1, 1'b1, 3,   1'b1};
        vecs[7] = '{8'h80, 9'd256, -1, 0, -1, 1'b0, 256, 1'b1};

        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        base_addr = '0; length = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Reset while a record is being held: everything back to reset values, no done.
        @(negedge clk);
        start = 1'b1; base_addr = 8'h40; length = 9'd4; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("midreset");
        saw = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || out_valid) saw = 1'b1;
        end
        check("midreset quiet", 32'(saw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
